// File: rtl/tensor_pkg.sv
// Shared types for the tensor command path: bitcast command layout,
// status codes, sequencer states and element-size decode.
package tensor_pkg;

  typedef struct packed {
    logic [4:0]  sub_field;
    logic [39:0] src_dim;
    logic [39:0] dstn_dim;
    logic [10:0] src_addr;
    logic [10:0] dstn_addr;
    logic [2:0]  in_size;
    logic [2:0]  out_size;
  } bitcast_cmd_t;

  localparam logic [2:0] STS_OK            = 3'd0;
  localparam logic [2:0] STS_SIZE_MISMATCH = 3'd1;
  localparam logic [2:0] STS_RANGE_OVF     = 3'd2;
  localparam logic [2:0] STS_EMPTY         = 3'd3;
  localparam logic [2:0] STS_OVERLAP       = 3'd4;
  localparam logic [2:0] STS_BAD_SIZE      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_CHECK, S_RUN, S_DRAIN, S_STATUS
  } state_t;

  // Element bytes are 1 << size; only sizes 0..3 are legal.
  function automatic logic elem_size_ok(input logic [2:0] size);
    return size < 3'd4;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; simultaneous push and pop are
// both honoured, including push while full when a pop frees the slot.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bitcast_sequencer.sv
// Executes one bitcast command: sizes and validates the ranges, then copies
// source words to destination through a credit-limited read buffer.
module bitcast_sequencer
  import tensor_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_BYTES = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_W      = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [112:0]            cmd_tdata,
  input  logic                    cmd_tvalid,
  output logic                    cmd_tready,
  output logic                    rd_req,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_gnt,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  input  logic                    rd_data_valid,
  output logic                    wr_req,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  input  logic                    wr_gnt,
  output logic [2:0]              sts_code,
  output logic [ADDR_W:0]         sts_words,
  output logic                    sts_tvalid,
  input  logic                    sts_tready,
  output logic                    busy
);
  localparam int DW    = 8*DATA_BYTES;
  localparam int PW    = 44;
  localparam int CW    = 48;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] SPACE = CW'(1) << ADDR_W;

  state_t           state, state_next;
  bitcast_cmd_t     cmd_r;
  logic [PW-1:0]    src_prod, dst_prod;
  logic [1:0]       calc_k;
  logic [DIM_W-1:0] src_dim_k, dst_dim_k;
  logic [ADDR_W:0]  words_r, issued, written, sts_words_r;
  logic [2:0]       code_r, chk_code;
  logic             chk_done, credit_ok, push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] outstanding, fifo_count;
  logic [DW-1:0]    fifo_head;
  logic [CW-1:0]    src_bytes, dst_bytes, words_c, src_a, dst_a;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic             unused_bits;

  assign unused_bits = ^{cmd_r.sub_field, fifo_full};
  assign src_dim_k   = cmd_r.src_dim[calc_k*DIM_W +: DIM_W];
  assign dst_dim_k   = cmd_r.dstn_dim[calc_k*DIM_W +: DIM_W];
  assign src_base    = ADDR_W'(cmd_r.src_addr);
  assign dst_base    = ADDR_W'(cmd_r.dstn_addr);

  // Range checks run at full product width so no address sum can wrap.
  always_comb begin
    src_bytes = CW'(src_prod) << cmd_r.in_size[1:0];
    dst_bytes = CW'(dst_prod) << cmd_r.out_size[1:0];
    words_c   = (src_bytes + CW'(DATA_BYTES-1)) >> $clog2(DATA_BYTES);
    src_a     = CW'(cmd_r.src_addr);
    dst_a     = CW'(cmd_r.dstn_addr);
    chk_done  = 1'b1;
    chk_code  = STS_OK;
    if (!elem_size_ok(cmd_r.in_size) || !elem_size_ok(cmd_r.out_size))
      chk_code = STS_BAD_SIZE;
    else if (src_prod == '0 || dst_prod == '0)
      chk_code = STS_EMPTY;
    else if (src_bytes != dst_bytes)
      chk_code = STS_SIZE_MISMATCH;
    else if ((src_a + words_c > SPACE) || (dst_a + words_c > SPACE))
      chk_code = STS_RANGE_OVF;
    else if (src_a == dst_a)
      chk_code = STS_OK;
    else if ((src_a < dst_a + words_c) && (dst_a < src_a + words_c))
      chk_code = STS_OVERLAP;
    else
      chk_done = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (cmd_tvalid) state_next = S_CALC;
      S_CALC:   if (calc_k == 2'd3) state_next = S_CHECK;
      S_CHECK:  state_next = chk_done ? S_STATUS : S_RUN;
      S_RUN:    if (issued == words_r) state_next = S_DRAIN;
      S_DRAIN:  if (written == words_r) state_next = S_STATUS;
      S_STATUS: if (sts_tready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
    cmd_tready = state == S_IDLE;
    busy       = state != S_IDLE;
    sts_tvalid = state == S_STATUS;
    rd_req     = (state == S_RUN) && (issued < words_r) && credit_ok;
    wr_req     = (state == S_RUN || state == S_DRAIN) && !fifo_empty;
  end

  assign push      = rd_data_valid && (state == S_RUN || state == S_DRAIN);
  assign pop       = wr_req && wr_gnt;
  assign rd_addr   = rd_req ? src_base + issued[ADDR_W-1:0] : '0;
  assign wr_addr   = wr_req ? dst_base + written[ADDR_W-1:0] : '0;
  assign wr_data   = wr_req ? fifo_head : '0;
  assign sts_code  = sts_tvalid ? code_r : '0;
  assign sts_words = sts_tvalid ? sts_words_r : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_r       <= '0;
      src_prod    <= '0;
      dst_prod    <= '0;
      calc_k      <= '0;
      words_r     <= '0;
      issued      <= '0;
      written     <= '0;
      outstanding <= '0;
      code_r      <= '0;
      sts_words_r <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_tvalid) begin
          cmd_r    <= cmd_tdata;
          src_prod <= PW'(1);
          dst_prod <= PW'(1);
          calc_k   <= '0;
        end
        S_CALC: begin
          src_prod <= src_prod * PW'(src_dim_k);
          dst_prod <= dst_prod * PW'(dst_dim_k);
          calc_k   <= calc_k + 2'd1;
        end
        S_CHECK: begin
          words_r     <= words_c[ADDR_W:0];
          issued      <= '0;
          written     <= '0;
          outstanding <= '0;
          if (chk_done) begin
            code_r      <= chk_code;
            sts_words_r <= (chk_code == STS_OK) ? words_c[ADDR_W:0] : '0;
          end
        end
        S_RUN, S_DRAIN: begin
          if (rd_req && rd_gnt) issued <= issued + (ADDR_W+1)'(1);
          if (pop) written <= written + (ADDR_W+1)'(1);
          outstanding <= outstanding + CNT_W'(rd_req && rd_gnt) - CNT_W'(push);
          if (state == S_DRAIN && written == words_r) begin
            code_r      <= STS_OK;
            sts_words_r <= words_r;
          end
        end
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (rd_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bitcast_sequencer.sv
// Bench for bitcast_sequencer: scratchpad responder plus a rule-level model
// of the command checks and the expected copy.
module tb_bitcast_sequencer;
  localparam int ADDR_W = 11, DATA_BYTES = 8, FIFO_DEPTH = 4;

  logic         clock = 1'b0, reset;
  logic [112:0] cmd_tdata;
  logic         cmd_tvalid, cmd_tready;
  logic         rd_req, rd_gnt, rd_data_valid;
  logic [10:0]  rd_addr, wr_addr;
  logic [63:0]  rd_data, wr_data;
  logic         wr_req, wr_gnt;
  logic [2:0]   sts_code;
  logic [11:0]  sts_words;
  logic         sts_tvalid, sts_tready, busy;

  bitcast_sequencer #(
    .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .FIFO_DEPTH(FIFO_DEPTH), .DIM_W(10)
  ) dut (
    .clock(clock), .reset(reset), .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .sts_code(sts_code),
    .sts_words(sts_words), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready), .busy(busy)
  );

  always #5 clock = ~clock;

  int vectors = 0, errors = 0;
  logic [63:0] smem [2048];
  typedef struct { int due; logic [10:0] addr; } pend_t;
  pend_t       pend_q[$];
  logic [10:0] rlog[$], wlog_a[$];
  logic [63:0] wlog_d[$];
  int cyc = 0, rd_lat = 2, wr_low_left = 0, reads_before_w = 0, stab_err = 0;
  int first_rd_cyc = 0, accept_cyc = 0;
  bit gnt_rand = 0, saw_rd = 0, any_req = 0, prev_rd_wait = 0;
  logic [10:0] prev_rd_addr = '0;

  // Scratchpad side: grants, in-order read returns, handshake logging.
  initial begin
    rd_gnt = 1'b0; wr_gnt = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        pend_q.delete();
        rd_data_valid = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0; prev_rd_wait = 0;
      end else begin
        rd_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (wr_low_left > 0) begin
          wr_gnt = 1'b0;
          if (wr_req) wr_low_left--;
        end else begin
          wr_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (prev_rd_wait && (!rd_req || rd_addr !== prev_rd_addr)) stab_err++;
        prev_rd_wait = rd_req && !rd_gnt;
        prev_rd_addr = rd_addr;
        if (cmd_tvalid && cmd_tready) accept_cyc = cyc;
        if (rd_req && !saw_rd) begin saw_rd = 1; first_rd_cyc = cyc; end
        if (rd_req || wr_req) any_req = 1;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          rd_data_valid = 1'b1;
          rd_data = smem[pend_q[0].addr];
          void'(pend_q.pop_front());
        end else begin
          rd_data_valid = 1'b0;
          rd_data = {$urandom, $urandom};
        end
        if (rd_req && rd_gnt) begin
          rlog.push_back(rd_addr);
          if (wlog_a.size() == 0) reads_before_w++;
          pend_q.push_back('{due: cyc + rd_lat, addr: rd_addr});
        end
        if (wr_req && wr_gnt) begin
          wlog_a.push_back(wr_addr);
          wlog_d.push_back(wr_data);
        end
      end
    end
  end

  function automatic logic [39:0] dims(input int d0, d1, d2, d3);
    return {10'(d3), 10'(d2), 10'(d1), 10'(d0)};
  endfunction

  function automatic logic [112:0] mk_cmd(input logic [39:0] sd, dd, input int sa, da,
                                          input int is, os);
    return {5'($urandom), sd, dd, 11'(sa), 11'(da), 3'(is), 3'(os)};
  endfunction

  // Rule-level model: products, byte counts and the prioritised checks.
  function automatic void ref_model(input logic [112:0] c, output logic [2:0] code,
                                    output logic [11:0] words);
    longint ps = 1, pd = 1, bs, bd, w, sa, da;
    for (int k = 0; k < 4; k++) begin
      ps *= longint'(c[68+10*k +: 10]);
      pd *= longint'(c[28+10*k +: 10]);
    end
    sa = longint'(c[27:17]); da = longint'(c[16:6]);
    code = 3'd0; words = '0;
    if (c[5:3] > 3 || c[2:0] > 3) code = 3'd5;
    else if (ps == 0 || pd == 0) code = 3'd3;
    else begin
      bs = ps * (longint'(1) << c[5:3]);
      bd = pd * (longint'(1) << c[2:0]);
      w  = (bs + DATA_BYTES - 1) / DATA_BYTES;
      if (bs != bd) code = 3'd1;
      else if (sa + w > 2048 || da + w > 2048) code = 3'd2;
      else if (sa == da) words = 12'(w);
      else if (sa < da + w && da < sa + w) code = 3'd4;
      else words = 12'(w);
    end
  endfunction

  // Number of deviations from an exact in-order copy of w words.
  function automatic int copy_errs(input int sa, da, w);
    int n = 0;
    if (rlog.size() != w) n++;
    if (wlog_a.size() != w) n++;
    for (int i = 0; i < w && i < rlog.size(); i++)
      if (int'(rlog[i]) != sa + i) n++;
    for (int i = 0; i < w && i < wlog_a.size(); i++)
      if (int'(wlog_a[i]) != da + i || wlog_d[i] !== smem[sa+i]) n++;
    return n;
  endfunction

  task automatic send_cmd(input logic [112:0] c);
    @(posedge clock); #1;
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    reads_before_w = 0; any_req = 0; saw_rd = 0; stab_err = 0;
    cmd_tdata = c; cmd_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cmd_tready) break;
    end
    @(posedge clock); #1;
    cmd_tvalid = 1'b0;
  endtask

  task automatic wait_sts(output logic [2:0] code, output logic [11:0] words);
    code = 'x; words = 'x;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (sts_tvalid) begin code = sts_code; words = sts_words; break; end
    end
    if (code === 3'bxxx) $display("status timeout at cycle %0d", cyc);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++; if (cmd_tready !== 1'b1) begin errors++; $display("FAIL reset_cmd_tready got %b exp 1", cmd_tready); end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (rd_req !== 1'b0)     begin errors++; $display("FAIL reset_rd_req got %b exp 0", rd_req); end
    vectors++; if (wr_req !== 1'b0)     begin errors++; $display("FAIL reset_wr_req got %b exp 0", wr_req); end
    vectors++; if (sts_tvalid !== 1'b0) begin errors++; $display("FAIL reset_sts_tvalid got %b exp 0", sts_tvalid); end
    vectors++; if (sts_code !== 3'd0)   begin errors++; $display("FAIL reset_sts_code got %0d exp 0", sts_code); end
    vectors++; if (sts_words !== 12'd0) begin errors++; $display("FAIL reset_sts_words got %0d exp 0", sts_words); end
    vectors++; if (rd_addr !== 11'd0)   begin errors++; $display("FAIL reset_rd_addr got %h exp 0", rd_addr); end
    vectors++; if (wr_addr !== 11'd0)   begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
    vectors++; if (wr_data !== 64'd0)   begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_basic_copy;
    logic [2:0] code; logic [11:0] words; int e;
    gnt_rand = 0; rd_lat = 2; sts_tready = 1'b0;
    send_cmd(mk_cmd(dims(16, 1, 1, 1), dims(8, 1, 1, 1), 'h010, 'h100, 2, 3));
    wait_sts(code, words);
    vectors++; if (code !== 3'd0)   begin errors++; $display("FAIL basic_code got %0d exp 0", code); end
    vectors++; if (words !== 12'd8) begin errors++; $display("FAIL basic_words got %0d exp 8", words); end
    e = copy_errs('h010, 'h100, 8);
    vectors++; if (e !== 0) begin errors++; $display("FAIL basic_copy got %0d bad transfers exp 0", e); end
    vectors++;
    if (!saw_rd || first_rd_cyc - accept_cyc < 6) begin
      errors++; $display("FAIL basic_first_read got %0d cycles exp >=6", first_rd_cyc - accept_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (sts_tvalid !== 1'b1 || sts_code !== 3'd0 || sts_words !== 12'd8) begin
        errors++; $display("FAIL basic_status_hold got v=%b c=%0d w=%0d exp v=1 c=0 w=8",
                           sts_tvalid, sts_code, sts_words);
      end
    end
    @(posedge clock); #1 sts_tready = 1'b1;
    @(posedge clock); @(negedge clock);
    vectors++;
    if (cmd_tready !== 1'b1 || sts_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_handshake got rdy=%b v=%b busy=%b exp 1 0 0",
                         cmd_tready, sts_tvalid, busy);
    end
  endtask

  task automatic test_errors;
    logic [112:0] c [4];
    logic [2:0]   expc [4];
    logic [2:0] code; logic [11:0] words;
    c[0] = mk_cmd(dims(16, 1, 1, 1), dims(16, 1, 1, 1), 'h010, 'h100, 2, 3); expc[0] = 3'd1;
    c[1] = mk_cmd(dims(16, 1, 1, 1), dims(8, 1, 1, 1), 'h7FC, 'h100, 2, 3);  expc[1] = 3'd2;
    c[2] = mk_cmd(dims(16, 0, 1, 1), dims(8, 1, 1, 1), 'h010, 'h100, 2, 3);  expc[2] = 3'd3;
    c[3] = mk_cmd(dims(16, 0, 1, 1), dims(3, 1, 1, 1), 'h7FF, 'h7FF, 5, 3);  expc[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      send_cmd(c[i]);
      wait_sts(code, words);
      vectors++; if (code !== expc[i]) begin errors++; $display("FAIL err%0d_code got %0d exp %0d", i, code, expc[i]); end
      vectors++; if (words !== 12'd0)  begin errors++; $display("FAIL err%0d_words got %0d exp 0", i, words); end
      vectors++; if (any_req !== 1'b0) begin errors++; $display("FAIL err%0d_traffic got %b exp 0", i, any_req); end
    end
  endtask

  task automatic test_backpressure;
    logic [2:0] code; logic [11:0] words; int e;
    gnt_rand = 0; rd_lat = 2; wr_low_left = 20;
    send_cmd(mk_cmd(dims(16, 1, 1, 1), dims(8, 1, 1, 1), 'h010, 'h100, 2, 3));
    wait_sts(code, words);
    vectors++; if (code !== 3'd0)   begin errors++; $display("FAIL bp_code got %0d exp 0", code); end
    vectors++; if (words !== 12'd8) begin errors++; $display("FAIL bp_words got %0d exp 8", words); end
    vectors++; if (reads_before_w > FIFO_DEPTH) begin errors++; $display("FAIL bp_credit got %0d reads exp <=4", reads_before_w); end
    e = copy_errs('h010, 'h100, 8);
    vectors++; if (e !== 0) begin errors++; $display("FAIL bp_copy got %0d bad transfers exp 0", e); end
  endtask

  task automatic test_same_overlap;
    logic [2:0] code; logic [11:0] words;
    send_cmd(mk_cmd(dims(16, 1, 1, 1), dims(8, 1, 1, 1), 'h010, 'h010, 2, 3));
    wait_sts(code, words);
    vectors++; if (code !== 3'd0)    begin errors++; $display("FAIL same_code got %0d exp 0", code); end
    vectors++; if (words !== 12'd8)  begin errors++; $display("FAIL same_words got %0d exp 8", words); end
    vectors++; if (any_req !== 1'b0) begin errors++; $display("FAIL same_traffic got %b exp 0", any_req); end
    send_cmd(mk_cmd(dims(16, 1, 1, 1), dims(8, 1, 1, 1), 'h010, 'h014, 2, 3));
    wait_sts(code, words);
    vectors++; if (code !== 3'd4)    begin errors++; $display("FAIL overlap_code got %0d exp 4", code); end
    vectors++; if (words !== 12'd0)  begin errors++; $display("FAIL overlap_words got %0d exp 0", words); end
    vectors++; if (any_req !== 1'b0) begin errors++; $display("FAIL overlap_traffic got %b exp 0", any_req); end
  endtask

  task automatic test_reset_mid_op;
    logic [2:0] code; logic [11:0] words; int e;
    logic [112:0] c;
    gnt_rand = 0; rd_lat = 3;
    c = mk_cmd(dims(16, 1, 1, 1), dims(8, 1, 1, 1), 'h020, 'h200, 2, 3);
    send_cmd(c);
    for (int i = 0; i < 200 && wlog_a.size() < 3; i++) begin @(posedge clock); #1; end
    vectors++; if (wlog_a.size() < 3) begin errors++; $display("FAIL midrst_writes got %0d exp >=3", wlog_a.size()); end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    vectors++;
    if (cmd_tready !== 1'b1 || busy !== 1'b0 || rd_req !== 1'b0 || wr_req !== 1'b0 ||
        sts_tvalid !== 1'b0 || wr_addr !== 11'd0 || rd_addr !== 11'd0 || wr_data !== 64'd0) begin
      errors++; $display("FAIL midrst_outputs got rdy=%b busy=%b rq=%b wq=%b v=%b exp 1 0 0 0 0",
                         cmd_tready, busy, rd_req, wr_req, sts_tvalid);
    end
    @(posedge clock); #1 reset = 1'b0;
    send_cmd(c);
    wait_sts(code, words);
    vectors++; if (code !== 3'd0)   begin errors++; $display("FAIL midrst_code got %0d exp 0", code); end
    vectors++; if (words !== 12'd8) begin errors++; $display("FAIL midrst_words got %0d exp 8", words); end
    e = copy_errs('h020, 'h200, 8);
    vectors++; if (e !== 0) begin errors++; $display("FAIL midrst_copy got %0d bad transfers exp 0", e); end
  endtask

  task automatic test_random;
    gnt_rand = 1;
    for (int n = 0; n < 16; n++) begin
      int unsigned d0, d1, isz, osz, dd0, bytes, sa, da;
      logic [112:0] c;
      logic [2:0] code, exp_code; logic [11:0] words, exp_words; int e;
      d0 = $urandom_range(1, 16); d1 = $urandom_range(1, 3);
      isz = $urandom_range(0, 3); osz = $urandom_range(0, 3);
      bytes = (d0 * d1) << isz;
      dd0 = (bytes % (1 << osz) == 0) ? bytes >> osz : d0;
      case ($urandom_range(0, 9))
        0: isz = $urandom_range(4, 7);
        1: d1 = 0;
        2: dd0 = dd0 + 1;
        default: ;
      endcase
      sa = $urandom_range(0, 2047);
      da = ($urandom_range(0, 3) == 0) ? ((sa + $urandom_range(0, 40)) % 2048) : $urandom_range(0, 2047);
      rd_lat = $urandom_range(1, 4);
      c = mk_cmd(dims(d0, d1, 1, 1), dims(1, 1, dd0, 1), sa, da, isz, osz);
      ref_model(c, exp_code, exp_words);
      send_cmd(c);
      wait_sts(code, words);
      vectors++; if (code !== exp_code)   begin errors++; $display("FAIL rnd%0d_code got %0d exp %0d", n, code, exp_code); end
      vectors++; if (words !== exp_words) begin errors++; $display("FAIL rnd%0d_words got %0d exp %0d", n, words, exp_words); end
      if (exp_code == 3'd0 && sa != da) begin
        e = copy_errs(sa, da, exp_words) + stab_err;
        vectors++; if (e !== 0) begin errors++; $display("FAIL rnd%0d_copy got %0d bad transfers exp 0", n, e); end
      end else begin
        vectors++; if (any_req !== 1'b0) begin errors++; $display("FAIL rnd%0d_traffic got %b exp 0", n, any_req); end
      end
    end
    gnt_rand = 0;
  endtask

  initial begin
    reset = 1'b1; cmd_tvalid = 1'b0; cmd_tdata = '0; sts_tready = 1'b1;
    for (int i = 0; i < 2048; i++) smem[i] = {$urandom, $urandom};
    test_reset();
    test_basic_copy();
    test_errors();
    test_backpressure();
    test_same_overlap();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bitcast_sequencer.md
Name: bitcast_sequencer

Overview:
Executes one bitcast command at a time, as emitted by the top-level config controller, by sequencing the shared scratchpad.
- Computes source and destination byte counts from the dimension and element-size fields.
- Validates the command, then streams words from the source range to the destination range through a small credit-limited read-data buffer.
- Reports completion or the error code on a status stream.
- Sits between the controller's bitcast output and the scratchpad read/write arbiter ports.

Parameters:
ADDR_W, 11, scratchpad word-address width
DATA_BYTES, 8, bytes per scratchpad word (power of two)
FIFO_DEPTH, 4, read-data buffer entries; also the cap on reads in flight plus buffered
DIM_W, 10, width of each of the 4 dimensions in a 40-bit dim field

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
cmd_tdata  in  113  [112:108] sub_field, [107:68] src_dim, [67:28] dstn_dim, [27:17] src_addr, [16:6] dstn_addr, [5:3] in_size, [2:0] out_size
cmd_tvalid  in  1  command valid
cmd_tready  out  1  high only in IDLE
rd_req  out  1  scratchpad read request
rd_addr  out  ADDR_W  read word address
rd_gnt  in  1  read accepted when rd_req&&rd_gnt
rd_data  in  8*DATA_BYTES  returned read word
rd_data_valid  in  1  read data valid; in order, latency >=1
wr_req  out  1  write request
wr_addr  out  ADDR_W  write word address
wr_data  out  8*DATA_BYTES  write word
wr_gnt  in  1  write accepted when wr_req&&wr_gnt
sts_code  out  3  0 ok, 1 size mismatch, 2 range overflow, 3 empty, 4 overlap, 5 bad element size
sts_words  out  ADDR_W+1  words copied; 0 on any error
sts_tvalid  out  1  status valid
sts_tready  in  1  status accepted
busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - State IDLE, cmd_tready=1.
  - rd_req, wr_req, sts_tvalid, busy = 0.
  - All addresses, data, sts_code and sts_words = 0.
  - FIFO empty; outstanding count 0.
- Reset mid-operation: reset returns the block to IDLE in the next cycle and abandons the command. The scratchpad arbiter shares this reset, so in-flight read data is discarded.
- Dimensions:
  - dim k occupies bits [10k+9:10k] of the field.
  - Element bytes = 1<<size for size 0..3; size 4..7 is invalid.
- FSM IDLE -> CALC -> CHECK -> RUN -> DRAIN -> STATUS -> IDLE.
- IDLE: on cmd_tvalid&&cmd_tready, latch the command and go to CALC. sub_field is carried but not interpreted.
- CALC: exactly 4 cycles. Each cycle multiplies both running products by dim k (k=0..3), 44-bit accumulators, init 1.
- CHECK (1 cycle): bytes = product<<size; words = (bytes+DATA_BYTES-1)/DATA_BYTES. Evaluated in priority order:
  - invalid in_size or out_size -> code 5;
  - either product 0 -> 3;
  - src bytes != dst bytes -> 1;
  - addr+words > 2^ADDR_W for src or dst -> 2;
  - src_addr == dstn_addr -> code 0, sts_words = words, no memory traffic;
  - ranges intersect -> 4;
  - otherwise -> RUN.
  - Every error case goes straight to STATUS.
- First rd_req is asserted no earlier than 6 cycles after the command is accepted.
- RUN, read side:
  - rd_req is asserted while issued < words and outstanding+fifo_count < FIFO_DEPTH.
  - rd_addr = src_addr + issued.
  - rd_req and rd_addr stay stable until granted.
- RUN, data and write side:
  - rd_data_valid pushes rd_data into the FIFO. The credit rule guarantees the FIFO never overflows.
  - wr_req is asserted whenever the FIFO is non-empty.
  - wr_data = FIFO head; wr_addr = dstn_addr + written.
  - Pop on wr_req&&wr_gnt.
  - Push and pop in the same cycle are both honoured.
- RUN -> DRAIN when issued == words. DRAIN -> STATUS when written == words.
- STATUS:
  - sts_tvalid=1; sts_code and sts_words are held until sts_tready.
  - Go to IDLE on the handshake. No new command is accepted before the handshake.
- Address arithmetic never wraps; the CHECK overflow test guarantees this.

Decomposition:
- Shared package (tensor_pkg):
  - bitcast_cmd_t packed struct matching the field layout above;
  - status code localparams STS_OK..STS_BAD_SIZE;
  - element-size decode function.
- One sub-module: sync_fifo (DEPTH, WIDTH; push/pop/full/empty/count), reused elsewhere.

Test Plan:
- Basic copy:
  - Stimulus: src_dim dim0=16 (others 1), in_size=2; dst dim0=8, out_size=3; src 0x010, dst 0x100; grants always high; read latency 2.
  - Response: 8 reads 0x010..0x017 and 8 writes 0x100..0x107 with matching data, then sts_code=0, sts_words=8.
- Size mismatch:
  - Stimulus: src dim0=16, in_size=2; dst dim0=16, out_size=3.
  - Response: no rd_req or wr_req; sts_code=1, sts_words=0.
- Range overflow and empty:
  - Overflow: src_addr=0x7FC with 8 words -> sts_code=2.
  - Empty: a dim=0 -> sts_code=3.
  - Bad size: in_size=5 -> sts_code=5 (priority over the other checks).
- Backpressure:
  - Stimulus: basic copy with wr_gnt low for 20 cycles.
  - Response: at most 4 reads accepted before the first write; all 8 words written in order with no loss or duplication; sts_code=0.
- Same and overlapping ranges:
  - src==dst -> no traffic, sts_code=0, sts_words=8.
  - src 0x010, dst 0x014, 8 words -> sts_code=4.
- Reset mid-operation:
  - Stimulus: assert reset after the 3rd write grant.
  - Response: next cycle all outputs at reset values and cmd_tready=1; a fresh command then completes normally.
